// File: rtl/arith_issue_arbiter.sv
// Round-robin issue arbiter: picks one ready reservation-station op per cycle
// and holds it in a single registered issue slot feeding the arithmetic FU.
module arith_issue_arbiter #(
    parameter int XLEN          = 32,
    parameter int ROB_SIZE      = 256,
    parameter int PHYS_REG_SIZE = 256,
    parameter int UOP_SIZE      = 16,
    parameter int NUM_REQ       = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  wb_stall,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*$clog2(UOP_SIZE)-1:0]   req_uop,
    input  logic [NUM_REQ*$clog2(ROB_SIZE)-1:0]   req_rob_entry,
    input  logic [NUM_REQ*$clog2(PHYS_REG_SIZE)-1:0] req_dest_reg,
    input  logic [NUM_REQ*XLEN-1:0]               req_rs1,
    input  logic [NUM_REQ*XLEN-1:0]               req_rs2,
    input  logic [NUM_REQ*XLEN-1:0]               req_pc,
    output logic [NUM_REQ-1:0]                    req_grant,
    output logic                                  fu_valid,
    output logic [$clog2(UOP_SIZE)-1:0]           fu_uop,
    output logic [$clog2(ROB_SIZE)-1:0]           fu_rob_entry,
    output logic [$clog2(PHYS_REG_SIZE)-1:0]      fu_dest_reg,
    output logic [XLEN-1:0]                       fu_rs1,
    output logic [XLEN-1:0]                       fu_rs2,
    output logic [XLEN-1:0]                       fu_pc,
    output logic [31:0]                           issue_count
);

    localparam int UOP_W  = $clog2(UOP_SIZE);
    localparam int ROB_W  = $clog2(ROB_SIZE);
    localparam int PREG_W = $clog2(PHYS_REG_SIZE);
    localparam int PTR_W  = $clog2(NUM_REQ);

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    logic [PTR_W-1:0]  rr_ptr;
    logic [31:0]       issue_cnt;
    logic              vld_p1;
    logic [UOP_W-1:0]  uop_p1;
    logic [ROB_W-1:0]  rob_p1;
    logic [PREG_W-1:0] dest_p1;
    logic [XLEN-1:0]   rs1_p1;
    logic [XLEN-1:0]   rs2_p1;
    logic [XLEN-1:0]   pc_p1;

    logic              accept_p0;
    logic              found_p0;
    logic              grant_p0;
    logic [PTR_W-1:0]  sel_p0;
    logic [PTR_W-1:0]  idx_p0;

    // Stage p0: rotating priority search starting at rr_ptr
    always_comb begin
        accept_p0 = !flush && (!vld_p1 || !wb_stall);
        found_p0  = 1'b0;
        sel_p0    = '0;
        idx_p0    = '0;
        // Walk from the farthest slot back so the nearest valid one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_p0 = rr_ptr + PTR_W'(k);
            if (req_valid[idx_p0]) begin
                found_p0 = 1'b1;
                sel_p0   = idx_p0;
            end
        end
        grant_p0  = !rst && accept_p0 && found_p0;
        req_grant = '0;
        if (grant_p0) req_grant[sel_p0] = 1'b1;
    end

    // Stage p1: issue slot register toward the FU
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            rr_ptr    <= '0;
            issue_cnt <= '0;
            uop_p1    <= '0;
            rob_p1    <= '0;
            dest_p1   <= '0;
            rs1_p1    <= '0;
            rs2_p1    <= '0;
            pc_p1     <= '0;
        end else if (grant_p0) begin
            vld_p1    <= 1'b1;
            rr_ptr    <= sel_p0 + PTR_W'(1);
            issue_cnt <= sat_inc(issue_cnt);
            uop_p1    <= req_uop[sel_p0*UOP_W +: UOP_W];
            rob_p1    <= req_rob_entry[sel_p0*ROB_W +: ROB_W];
            dest_p1   <= req_dest_reg[sel_p0*PREG_W +: PREG_W];
            rs1_p1    <= req_rs1[sel_p0*XLEN +: XLEN];
            rs2_p1    <= req_rs2[sel_p0*XLEN +: XLEN];
            pc_p1     <= req_pc[sel_p0*XLEN +: XLEN];
        end else if (flush || accept_p0) begin
            vld_p1 <= 1'b0;
        end
    end

    assign fu_valid     = vld_p1;
    assign fu_uop       = uop_p1;
    assign fu_rob_entry = rob_p1;
    assign fu_dest_reg  = dest_p1;
    assign fu_rs1       = rs1_p1;
    assign fu_rs2       = rs2_p1;
    assign fu_pc        = pc_p1;
    assign issue_count  = issue_cnt;

endmodule

// File: doc/arith_issue_arbiter.md
ARITH_ISSUE_ARBITER -- requirements
Module: arith_issue_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter ROB_SIZE, default 256, ROB entries; tag width $clog2(ROB_SIZE).
REQ-003 Parameter PHYS_REG_SIZE, default 256, physical registers; tag width $clog2(PHYS_REG_SIZE).
REQ-004 Parameter UOP_SIZE, default 16, uop encodings; uop width $clog2(UOP_SIZE).
REQ-005 Parameter NUM_REQ, default 4, reservation-station requesters; power of two, >=2.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 flush  in  1  pipeline flush; kills the held issue slot.
REQ-009 wb_stall  in  1  downstream cannot consume the issued op this cycle.
REQ-010 req_valid  in  NUM_REQ  per-requester op ready to issue.
REQ-011 req_uop  in  NUM_REQ*uopW  packed uops, requester i at slice i.
REQ-012 req_rob_entry  in  NUM_REQ*robW  packed ROB tags.
REQ-013 req_dest_reg  in  NUM_REQ*pregW  packed destination tags.
REQ-014 req_rs1, req_rs2, req_pc  in  NUM_REQ*XLEN each  packed operands and PC.
REQ-015 req_grant  out  NUM_REQ  one-hot combinational accept; requester retires op in the same cycle.
REQ-016 fu_valid  out  1  registered issue-slot valid to arithmetic FU valid_in.
REQ-017 fu_uop, fu_rob_entry, fu_dest_reg, fu_rs1, fu_rs2, fu_pc  out  matching widths  registered payload to FU.
REQ-018 issue_count  out  32  saturating count of accepted grants.

Function
REQ-019 accept SHALL equal !flush && (!fu_valid || !wb_stall).
REQ-020 req_grant SHALL be zero when accept is 0 or no req_valid bit is set.
REQ-021 Otherwise req_grant SHALL select the first set req_valid bit searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-022 req_grant SHALL have at most one bit set in every cycle.
REQ-023 rr_ptr ($clog2(NUM_REQ) bits) SHALL update to (granted index + 1) mod NUM_REQ on a grant, else hold.
REQ-024 On a grant, the granted requester's payload SHALL load into the fu_* registers and fu_valid SHALL be 1 next cycle (latency 1).
REQ-025 When fu_valid=1 and wb_stall=1 (no flush), fu_valid and all fu_* payload SHALL hold unchanged.
REQ-026 When accept=1 and no requester is valid, fu_valid SHALL become 0 next cycle; payload MAY hold.
REQ-027 flush=1 SHALL force fu_valid to 0 next cycle regardless of wb_stall, issue no grant that cycle, and leave rr_ptr unchanged.
REQ-028 issue_count SHALL increment by 1 on every grant and saturate at 0xFFFFFFFF.
REQ-029 Back-to-back grants SHALL sustain one issue per cycle while wb_stall=0.
REQ-030 Wrap-around: granted index NUM_REQ-1 SHALL set rr_ptr to 0.

Reset
REQ-031 While rst=1: fu_valid=0, all fu_* payload=0, rr_ptr=0, issue_count=0, req_grant=0.
REQ-032 rst SHALL take priority over flush, wb_stall and requests; an in-flight op is dropped without a grant.
REQ-033 First cycle after rst deasserts SHALL arbitrate normally from rr_ptr=0.

Verification
REQ-034 Reset then req_valid=4'b1111, wb_stall=0 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; fu_rob_entry tracks each requester's tag one cycle later; issue_count=5.
REQ-035 req_valid=4'b1010 from rr_ptr=0 -> grant 0010, then 1000, then 0010; rr_ptr wraps to 0 after index 3.
REQ-036 Issue op (rob 8'h12); assert wb_stall 3 cycles with req_valid=4'b0001 -> req_grant=0, fu payload holds rob 8'h12; first cycle after release -> grant 0001.
REQ-037 fu_valid=1, wb_stall=1, flush=1 with req_valid=4'b0100 -> no grant, fu_valid=0 next cycle, rr_ptr unchanged; next cycle grant 0100.
REQ-038 rst asserted while fu_valid=1 and req_valid=4'b1111 -> next cycle fu_valid=0, issue_count=0, req_grant=0; after release first grant 0001.
REQ-039 Preload issue_count near 0xFFFFFFFF (force) and issue 3 ops -> counter stays 0xFFFFFFFF.
